// File: rtl/sys_arr_feeder_if.sv
// Bundle of the feeder's control, source-stream, array-side and writeback signals.
// master = feeder side, slave = surrounding environment (sources, array, scratchpad).
interface sys_arr_feeder_if #(
    parameter int N  = 4,
    parameter int DW = 16
);
    localparam int IW = $clog2(N);

    logic            start;
    logic            busy;
    logic            done;
    logic            start_rej;

    logic            src_valid;
    logic            src_ready;
    logic [DW*N-1:0] src_data;
    logic            ps_valid;
    logic            ps_ready;
    logic [DW*N-1:0] ps_data;

    logic            weight_en;
    logic            input_en;
    logic            partial_en;
    logic [IW-1:0]   row_in_en;
    logic [IW-1:0]   row_ps_en;
    logic [DW*N-1:0] array_in;
    logic [DW*N-1:0] array_in_partials;

    logic            drained;
    logic            fifo_has_space;
    logic            out_en;
    logic [IW-1:0]   row_out;
    logic [DW*N-1:0] array_output;

    logic            wb_valid;
    logic [IW-1:0]   wb_row;
    logic [DW*N-1:0] wb_data;
    logic            row_err;

    logic [1:0]      dbg_state;

    modport master (
        input  start, src_valid, src_data, ps_valid, ps_data,
               drained, fifo_has_space, out_en, row_out, array_output,
        output busy, done, start_rej, src_ready, ps_ready,
               weight_en, input_en, partial_en, row_in_en, row_ps_en,
               array_in, array_in_partials, wb_valid, wb_row, wb_data, row_err,
               dbg_state
    );

    modport slave (
        output start, src_valid, src_data, ps_valid, ps_data,
               drained, fifo_has_space, out_en, row_out, array_output,
        input  busy, done, start_rej, src_ready, ps_ready,
               weight_en, input_en, partial_en, row_in_en, row_ps_en,
               array_in, array_in_partials, wb_valid, wb_row, wb_data, row_err,
               dbg_state
    );
endinterface

// File: rtl/sys_arr_feeder.sv
// Memory-side systolic array feeder: loads N weight rows, then N input rows alongside
// N partial-sum rows, waits for the array to drain, and registers array output rows.
module sys_arr_feeder #(
    parameter int N  = 4,
    parameter int DW = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    sys_arr_feeder_if.master bus
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    // Handshake rule for both source streams: a row transfers on a rising CLK edge
    // where valid and ready are both 1; ready depends only on registered state.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_W     = 2'd1,
        LOAD_IN    = 2'd2,
        WAIT_DRAIN = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_w_cnt, r_in_cnt, r_ps_cnt, r_exp_row;
    logic            r_in_done, r_ps_done;
    logic            r_done, r_start_rej;
    logic            r_weight_en, r_input_en, r_partial_en;
    logic [IW-1:0]   r_row_in_en, r_row_ps_en;
    logic [DW*N-1:0] r_array_in, r_array_in_partials;
    logic            r_wb_valid, r_row_err;
    logic [IW-1:0]   r_wb_row;
    logic [DW*N-1:0] r_wb_data;
    logic            w_src_ready, w_ps_ready, w_src_hs, w_ps_hs;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // LOAD_IN exit looks ahead: a stream is finished if its flag is set or its last row lands now.
    always_comb begin
        w_state_nxt = r_state;
        w_src_ready = 1'b0;
        w_ps_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && bus.fifo_has_space) w_state_nxt = LOAD_W;
            end
            LOAD_W: begin
                w_src_ready = 1'b1;
                if (bus.src_valid && r_w_cnt == LAST) w_state_nxt = LOAD_IN;
            end
            LOAD_IN: begin
                w_src_ready = !r_in_done;
                w_ps_ready  = !r_ps_done;
                if ((r_in_done || (bus.src_valid && r_in_cnt == LAST)) &&
                    (r_ps_done || (bus.ps_valid && r_ps_cnt == LAST)))
                    w_state_nxt = WAIT_DRAIN;
            end
            WAIT_DRAIN: begin
                if (bus.drained) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_src_hs = bus.src_valid && w_src_ready;
    assign w_ps_hs  = bus.ps_valid && w_ps_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_w_cnt     <= '0;
            r_in_cnt    <= '0;
            r_ps_cnt    <= '0;
            r_in_done   <= 1'b0;
            r_ps_done   <= 1'b0;
            r_done      <= 1'b0;
            r_start_rej <= 1'b0;
        end else begin
            r_done      <= (r_state == WAIT_DRAIN) && bus.drained;
            r_start_rej <= bus.start && ((r_state != IDLE) || !bus.fifo_has_space);
            case (r_state)
                LOAD_W: begin
                    if (w_src_hs) r_w_cnt <= r_w_cnt + 1'b1;
                end
                LOAD_IN: begin
                    if (w_src_hs) begin
                        r_in_cnt <= r_in_cnt + 1'b1;
                        if (r_in_cnt == LAST) r_in_done <= 1'b1;
                    end
                    if (w_ps_hs) begin
                        r_ps_cnt <= r_ps_cnt + 1'b1;
                        if (r_ps_cnt == LAST) r_ps_done <= 1'b1;
                    end
                end
                WAIT_DRAIN: begin
                    if (bus.drained) begin
                        r_w_cnt   <= '0;
                        r_in_cnt  <= '0;
                        r_ps_cnt  <= '0;
                        r_in_done <= 1'b0;
                        r_ps_done <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array side: strobes pulse only on a handshake; index and data hold otherwise.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_weight_en         <= 1'b0;
            r_input_en          <= 1'b0;
            r_partial_en        <= 1'b0;
            r_row_in_en         <= '0;
            r_row_ps_en         <= '0;
            r_array_in          <= '0;
            r_array_in_partials <= '0;
        end else begin
            r_weight_en  <= w_src_hs && (r_state == LOAD_W);
            r_input_en   <= w_src_hs && (r_state == LOAD_IN);
            r_partial_en <= w_ps_hs;
            if (w_src_hs) begin
                r_row_in_en <= (r_state == LOAD_W) ? r_w_cnt : r_in_cnt;
                r_array_in  <= bus.src_data;
            end
            if (w_ps_hs) begin
                r_row_ps_en         <= r_ps_cnt;
                r_array_in_partials <= bus.ps_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wb_valid <= 1'b0;
            r_wb_row   <= '0;
            r_wb_data  <= '0;
            r_exp_row  <= '0;
            r_row_err  <= 1'b0;
        end else begin
            r_wb_valid <= bus.out_en;
            if (bus.out_en) begin
                r_wb_row  <= bus.row_out;
                r_wb_data <= bus.array_output;
                r_exp_row <= r_exp_row + 1'b1;
                if (bus.row_out != r_exp_row) r_row_err <= 1'b1;
            end
        end
    end

    assign bus.busy              = (r_state != IDLE);
    assign bus.done              = r_done;
    assign bus.start_rej         = r_start_rej;
    assign bus.src_ready         = w_src_ready;
    assign bus.ps_ready          = w_ps_ready;
    assign bus.weight_en         = r_weight_en;
    assign bus.input_en          = r_input_en;
    assign bus.partial_en        = r_partial_en;
    assign bus.row_in_en         = r_row_in_en;
    assign bus.row_ps_en         = r_row_ps_en;
    assign bus.array_in          = r_array_in;
    assign bus.array_in_partials = r_array_in_partials;
    assign bus.wb_valid          = r_wb_valid;
    assign bus.wb_row            = r_wb_row;
    assign bus.wb_data           = r_wb_data;
    assign bus.row_err           = r_row_err;
    assign bus.dbg_state         = r_state;
endmodule

// File: tb/tb_sys_arr_feeder.sv
// Self-checking bench for sys_arr_feeder: random row streams scored against a
// row-counting model of the GEMM load sequence and an in-order writeback model.
module tb_sys_arr_feeder;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = $clog2(N);
    localparam int RW = DW * N;
    localparam int SW = 12 + 3 * IW + 3 * RW;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    sys_arr_feeder_if #(.N(N), .DW(DW)) bus();
    sys_arr_feeder #(.N(N), .DW(DW)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    logic [RW-1:0] w_rows [N];
    logic [RW-1:0] i_rows [N];
    logic [RW-1:0] p_rows [N];
    logic [RW-1:0] last_in = '0;
    logic [RW-1:0] last_ps = '0;

    function automatic logic [SW-1:0] snap_outputs();
        return {bus.busy, bus.done, bus.start_rej, bus.src_ready, bus.ps_ready,
                bus.weight_en, bus.input_en, bus.partial_en, bus.row_in_en, bus.row_ps_en,
                bus.array_in, bus.array_in_partials, bus.wb_valid, bus.wb_row,
                bus.wb_data, bus.row_err, bus.dbg_state};
    endfunction

    function automatic logic [RW-1:0] rand_row();
        return {$urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        bus.start = 0; bus.src_valid = 0; bus.src_data = '0; bus.ps_valid = 0;
        bus.ps_data = '0; bus.drained = 0; bus.fifo_has_space = 0; bus.out_en = 0;
        bus.row_out = '0; bus.array_output = '0;
    endtask

    task automatic random_rows();
        for (int r = 0; r < N; r++) begin
            w_rows[r] = rand_row(); i_rows[r] = rand_row(); p_rows[r] = rand_row();
        end
    endtask

    // One full GEMM load; duty is the per-cycle percentage chance a source offers a row.
    task automatic do_gemm(input int duty, input int drain_wait, input bit extra_start);
        int w_tk = 0, in_tk = 0, ps_tk = 0, cyc = 0;
        logic e_w = 0, e_i = 0, e_p = 0, e_rej = 0;
        logic [IW-1:0] e_ri = '0, e_rp = '0;
        logic exp_src_rdy, exp_ps_rdy, sv, pv;
        bus.fifo_has_space = 1; bus.drained = 0;
        @(negedge CLK); bus.start = 1;
        @(negedge CLK); bus.start = 0;
        vectors++;
        if ({bus.busy, bus.start_rej, bus.done} !== 3'b100) begin
            miscompares++;
            $display("FAIL start_accept: busy/rej/done got %b want 100", {bus.busy, bus.start_rej, bus.done});
        end
        forever begin
            vectors++;
            if ({bus.weight_en, bus.input_en, bus.partial_en} !== {e_w, e_i, e_p}) begin
                miscompares++;
                $display("FAIL strobes cyc %0d: got %b want %b", cyc,
                         {bus.weight_en, bus.input_en, bus.partial_en}, {e_w, e_i, e_p});
            end
            vectors++;
            if (bus.array_in !== last_in || bus.array_in_partials !== last_ps) begin
                miscompares++;
                $display("FAIL row_data cyc %0d: got %h/%h want %h/%h", cyc,
                         bus.array_in, bus.array_in_partials, last_in, last_ps);
            end
            if (e_w || e_i) begin
                vectors++;
                if (bus.row_in_en !== e_ri) begin
                    miscompares++;
                    $display("FAIL row_in_en cyc %0d: got %0d want %0d", cyc, bus.row_in_en, e_ri);
                end
            end
            if (e_p) begin
                vectors++;
                if (bus.row_ps_en !== e_rp) begin
                    miscompares++;
                    $display("FAIL row_ps_en cyc %0d: got %0d want %0d", cyc, bus.row_ps_en, e_rp);
                end
            end
            vectors++;
            if (bus.start_rej !== e_rej) begin
                miscompares++;
                $display("FAIL start_rej_busy cyc %0d: got %b want %b", cyc, bus.start_rej, e_rej);
            end
            exp_src_rdy = (w_tk < N) || (in_tk < N);
            exp_ps_rdy  = (w_tk == N) && (ps_tk < N);
            vectors++;
            if ({bus.src_ready, bus.ps_ready, bus.busy, bus.done} !== {exp_src_rdy, exp_ps_rdy, 2'b10}) begin
                miscompares++;
                $display("FAIL ready_busy cyc %0d: got %b want %b", cyc,
                         {bus.src_ready, bus.ps_ready, bus.busy, bus.done}, {exp_src_rdy, exp_ps_rdy, 2'b10});
            end
            if (!exp_src_rdy && !exp_ps_rdy) break;
            if (cyc > 400) begin
                miscompares++;
                $display("FAIL load_timeout: rows taken %0d/%0d/%0d", w_tk, in_tk, ps_tk);
                break;
            end
            sv = exp_src_rdy && ($urandom_range(99) < duty);
            pv = (ps_tk < N) && ($urandom_range(99) < duty);
            bus.src_valid = sv;
            bus.src_data  = !sv ? rand_row() : (w_tk < N) ? w_rows[w_tk] : i_rows[in_tk];
            bus.ps_valid  = pv;
            bus.ps_data   = pv ? p_rows[ps_tk] : rand_row();
            bus.start     = extra_start && (cyc == 0);
            e_rej = bus.start;
            e_w = sv && (w_tk < N);
            e_i = sv && (w_tk == N);
            e_p = pv && exp_ps_rdy;
            if (e_w) begin
                e_ri = IW'(w_tk); last_in = w_rows[w_tk]; w_tk++;
            end else if (e_i) begin
                e_ri = IW'(in_tk); last_in = i_rows[in_tk]; in_tk++;
            end
            if (e_p) begin
                e_rp = IW'(ps_tk); last_ps = p_rows[ps_tk]; ps_tk++;
            end
            cyc++;
            @(negedge CLK);
            bus.start = 0;
        end
        bus.src_valid = 0; bus.ps_valid = 0;
        repeat (drain_wait) begin
            @(negedge CLK);
            vectors++;
            if ({bus.done, bus.busy, bus.src_ready, bus.ps_ready, bus.weight_en, bus.input_en, bus.partial_en} !== 7'b0100000) begin
                miscompares++;
                $display("FAIL drain_hold: done/busy/rdy/strobes got %b want 0100000",
                         {bus.done, bus.busy, bus.src_ready, bus.ps_ready, bus.weight_en, bus.input_en, bus.partial_en});
            end
        end
        bus.drained = 1;
        @(negedge CLK);
        bus.drained = 0;
        vectors++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL done_pulse: done/busy got %b want 10", {bus.done, bus.busy});
        end
        @(negedge CLK);
        vectors++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL done_single: done/busy got %b want 00", {bus.done, bus.busy});
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 0;
        repeat (2) @(negedge CLK);
        vectors++;
        if (snap_outputs() !== '0) begin
            miscompares++;
            $display("FAIL reset_state: outputs got %h want 0", snap_outputs());
        end
        nRST = 1;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v;
        for (int r = 0; r < N; r++) begin
            v = 16'h0001 + DW'(r); w_rows[r] = {N{v}};
            v = 16'h0011 + DW'(r); i_rows[r] = {N{v}};
            v = 16'h0021 + DW'(r); p_rows[r] = {N{v}};
        end
        do_gemm(100, 0, 0);
    endtask

    task automatic test_random_gaps();
        for (int g = 0; g < 3; g++) begin
            random_rows();
            do_gemm(50, int'($urandom_range(3)), 0);
        end
    endtask

    task automatic test_start_rej();
        @(negedge CLK);
        bus.fifo_has_space = 0; bus.start = 1;
        @(negedge CLK);
        bus.start = 0;
        vectors++;
        if ({bus.start_rej, bus.busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL rej_no_space: rej/busy got %b want 10", {bus.start_rej, bus.busy});
        end
        @(negedge CLK);
        vectors++;
        if ({bus.start_rej, bus.busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL rej_single: rej/busy got %b want 00", {bus.start_rej, bus.busy});
        end
        random_rows();
        do_gemm(80, 1, 1);
    endtask

    task automatic test_capture();
        int seq [8] = '{0, 1, 2, 3, 0, 2, 2, 3};
        int exp_row = 0;
        logic err = 0;
        logic [RW-1:0] d;
        for (int k = 0; k < 8; k++) begin
            d = rand_row();
            bus.out_en = 1; bus.row_out = IW'(seq[k]); bus.array_output = d;
            if (seq[k] != exp_row) err = 1;
            exp_row = (exp_row + 1) % N;
            @(negedge CLK);
            bus.out_en = 0; bus.array_output = rand_row();
            vectors++;
            if ({bus.wb_valid, bus.wb_row, bus.wb_data, bus.row_err} !== {1'b1, IW'(seq[k]), d, err}) begin
                miscompares++;
                $display("FAIL writeback %0d: valid/row/data/err got %b/%0d/%h/%b want 1/%0d/%h/%b", k,
                         bus.wb_valid, bus.wb_row, bus.wb_data, bus.row_err, seq[k], d, err);
            end
            if ($urandom_range(1) == 1) begin
                @(negedge CLK);
                vectors++;
                if ({bus.wb_valid, bus.row_err} !== {1'b0, err}) begin
                    miscompares++;
                    $display("FAIL wb_idle %0d: valid/err got %b want %b", k, {bus.wb_valid, bus.row_err}, {1'b0, err});
                end
            end
        end
    endtask

    task automatic test_reset_mid_gemm();
        random_rows();
        @(negedge CLK); bus.fifo_has_space = 1; bus.start = 1;
        @(negedge CLK); bus.start = 0; bus.src_valid = 1; bus.src_data = w_rows[0];
        @(negedge CLK); bus.src_data = w_rows[1];
        @(negedge CLK); bus.src_valid = 0;
        #2 nRST = 0;
        #1;
        vectors++;
        if (snap_outputs() !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_gemm: outputs got %h want 0", snap_outputs());
        end
        last_in = '0; last_ps = '0;
        repeat (2) @(negedge CLK);
        nRST = 1;
        @(negedge CLK);
        vectors++;
        if ({bus.done, bus.busy, bus.weight_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL post_reset_idle: done/busy/weight_en got %b want 000", {bus.done, bus.busy, bus.weight_en});
        end
        random_rows();
        do_gemm(70, 0, 0);
    endtask

    task automatic test_drain_wait();
        random_rows();
        do_gemm(100, 20, 0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_random_gaps();
        test_start_rej();
        test_capture();
        test_reset_mid_gemm();
        test_drain_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
